// File: rtl/daddr9_encoder_pkg.sv
// Shared constants and the packed D-format word layout for the DAddr9 encoder.
package daddr_enc_pkg;

  localparam int OPC_LSB   = 21;
  localparam int DADDR_LSB = 12;
  localparam int RN_LSB    = 5;
  localparam int DADDR_W   = 9;

  localparam logic [10:0] OPC_STUR = 11'h7C0;
  localparam logic [10:0] OPC_LDUR = 11'h7C2;

  typedef struct packed {
    logic [10:0]        opcode;
    logic [DADDR_W-1:0] daddr;
    logic [1:0]         op2;
    logic [4:0]         rn;
    logic [4:0]         rt;
  } dform_t;

endpackage

// File: rtl/daddr9_encoder_se_fit_check.sv
// Narrows a 64-bit signed offset to the 9-bit DAddr9 field and flags whether it fits.
// Build option DADDR9_SAT_EN: out-of-range offsets clamp to 9'h0FF / 9'h100 instead of truncating.
module se_fit_check
  import daddr_enc_pkg::*;
(
  input  logic [63:0]        offset,
  output logic               fits,
  output logic [DADDR_W-1:0] field
);

  // Bits 63:8 must all equal the 9-bit field's sign bit for the value to survive narrowing.
  assign fits = (&offset[63:8]) | ~(|offset[63:8]);

`ifdef DADDR9_SAT_EN
  always_comb begin
    field = offset[DADDR_W-1:0];
    if (!fits) field = offset[63] ? 9'h100 : 9'h0FF;
  end
`else
  assign field = offset[DADDR_W-1:0];
`endif

endmodule

// File: rtl/daddr9_encoder.sv
// Two-stage LDUR/STUR encoder: S1 holds the request and fit flag, S2 holds the packed word.
// Out-of-range field handling follows the DADDR9_SAT_EN build option inside se_fit_check.
module daddr9_encoder
  import daddr_enc_pkg::*;
#(
  parameter int ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [10:0]         in_opcode,
  input  logic [4:0]          in_rn,
  input  logic [4:0]          in_rt,
  input  logic [63:0]         in_offset,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [31:0]         out_instr,
  output logic                out_oor,
  output logic [ERRCNT_W-1:0] err_count
);

  logic               fits;
  logic [DADDR_W-1:0] field;

  se_fit_check u_fit (
    .offset (in_offset),
    .fits   (fits),
    .field  (field)
  );

  logic               s1_valid;
  logic               s1_fits;
  logic [10:0]        s1_opcode;
  logic [DADDR_W-1:0] s1_field;
  logic [4:0]         s1_rn;
  logic [4:0]         s1_rt;
  logic               s2_adv;
  logic               s1_adv;
  dform_t             word;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv && !reset;

  assign word = '{opcode: s1_opcode, daddr: s1_field, op2: 2'b00, rn: s1_rn, rt: s1_rt};

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_fits   <= 1'b0;
      s1_opcode <= '0;
      s1_field  <= '0;
      s1_rn     <= '0;
      s1_rt     <= '0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_oor   <= 1'b0;
      err_count <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_fits   <= fits;
          s1_opcode <= in_opcode;
          s1_field  <= field;
          s1_rn     <= in_rn;
          s1_rt     <= in_rt;
        end
      end
      if (s2_adv) begin
        out_valid <= s1_valid;
        if (s1_valid) begin
          out_instr <= word;
          out_oor   <= !s1_fits;
        end
      end
      // Counts delivered words only, so a stalled out-of-range word is counted once.
      if (out_valid && out_ready && out_oor && !(&err_count))
        err_count <= err_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_daddr9_encoder.sv
// Scoreboard bench for daddr9_encoder; expectations follow the DADDR9_SAT_EN build option.
module tb_daddr9_encoder;

  localparam logic [10:0] STUR = 11'h7C0;
  localparam logic [10:0] LDUR = 11'h7C2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic [10:0] in_opcode = '0;
  logic [4:0]  in_rn = '0;
  logic [4:0]  in_rt = '0;
  logic [63:0] in_offset = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, out_oor;
  logic [31:0] out_instr;
  logic [15:0] err_count;
  logic        in_ready2, out_valid2, out_oor2;
  logic [31:0] out_instr2;
  logic [1:0]  err2;

  daddr9_encoder #(.ERRCNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rn(in_rn), .in_rt(in_rt), .in_offset(in_offset),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_oor(out_oor), .err_count(err_count)
  );

  // Narrow counter copy sharing the same traffic, to exercise saturation.
  daddr9_encoder #(.ERRCNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
    .in_opcode(in_opcode), .in_rn(in_rn), .in_rt(in_rt), .in_offset(in_offset),
    .out_valid(out_valid2), .out_ready(out_ready), .out_instr(out_instr2),
    .out_oor(out_oor2), .err_count(err2)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          model_err = 0;
  bit          run = 0;
  bit          saw_block = 0;
  logic [32:0] sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: range test on the signed value, then clamp or wrap the field.
  function automatic logic [32:0] ref_word(input logic [10:0] opc, input logic [4:0] rn,
                                            input logic [4:0] rt, input longint off);
    logic [63:0] u;
    logic [8:0]  f;
    bit          in_range;
    u = off;
    f = u[8:0];
    in_range = (off >= -256) && (off <= 255);
`ifdef DADDR9_SAT_EN
    if (!in_range) f = (off < 0) ? 9'h100 : 9'h0FF;
`endif
    return {!in_range, opc, f, 2'b00, rn, rt};
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic cyc(input logic v, input logic [10:0] opc, input logic [4:0] rn,
                     input logic [4:0] rt, input longint off, input logic [32:0] exp,
                     input logic ordy, output logic acc);
    logic exp_rdy;
    @(negedge clk);
    out_ready = ordy;
    in_valid  = v;
    in_opcode = opc;
    in_rn     = rn;
    in_rt     = rt;
    in_offset = off;
    #1;
    exp_rdy = (sb.size() < 2) || ordy;
    check("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    check("in_ready_w2", {63'd0, in_ready2}, {63'd0, exp_rdy});
    if (v && !in_ready) saw_block = 1;
    acc = v && in_ready;
    if (acc) sb.push_back(exp);
  endtask

  task automatic idle(input logic ordy);
    logic acc;
    cyc(1'b0, '0, '0, '0, 0, '0, ordy, acc);
  endtask

  task automatic send(input logic [10:0] opc, input logic [4:0] rn, input logic [4:0] rt,
                      input longint off, input logic [32:0] exp, input logic ordy);
    logic acc;
    acc = 0;
    for (int i = 0; i < 30 && !acc; i++) cyc(1'b1, opc, rn, rt, off, exp, ordy, acc);
    if (!acc) check("send_timeout", 64'd0, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb.size() != 0; i++) idle(1'b1);
    check("drain_empty", 64'(sb.size()), 64'd0);
    idle(1'b1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    sb.delete();
    model_err = 0;
    #1;
    check("in_ready_in_reset", {63'd0, in_ready}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_instr", {32'd0, out_instr}, 64'd0);
    check("rst_out_oor", {63'd0, out_oor}, 64'd0);
    check("rst_err_count", {48'd0, err_count}, 64'd0);
  endtask

  // Request is visible on the output in the second cycle after the one presenting it.
  task automatic lat_req(input logic [10:0] opc, input logic [4:0] rn, input logic [4:0] rt,
                         input longint off, input logic [32:0] exp);
    send(opc, rn, rt, off, exp, 1'b1);
    idle(1'b1);
    check("lat_first_cycle", {63'd0, out_valid}, 64'd0);
    idle(1'b1);
    check("lat_second_cycle", {63'd0, out_valid}, 64'd1);
  endtask

  // Monitor: samples mid-cycle, pops on each handshake that the next edge will complete.
  initial begin
    bit          held = 0;
    logic [31:0] held_instr = '0;
    logic        held_oor = 0;
    logic [32:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (reset || !run) begin
        held = 0;
        continue;
      end
      check("err_count", {48'd0, err_count}, 64'(sat(model_err, 65535)));
      check("err_count_w2", {62'd0, err2}, 64'(sat(model_err, 3)));
      if (held) begin
        check("stall_valid", {63'd0, out_valid}, 64'd1);
        check("stall_instr", {32'd0, out_instr}, {32'd0, held_instr});
        check("stall_oor", {63'd0, out_oor}, {63'd0, held_oor});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_word", {32'd0, out_instr}, 64'd0);
        end else begin
          e = sb.pop_front();
          check("out_instr", {32'd0, out_instr}, {32'd0, e[31:0]});
          check("out_oor", {63'd0, out_oor}, {63'd0, e[32]});
          check("out_instr_w2", {32'd0, out_instr2}, {32'd0, e[31:0]});
          if (out_oor) model_err++;
        end
      end
      held = out_valid && !out_ready;
      held_instr = out_instr;
      held_oor = out_oor;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc;
    logic [10:0] opc;
    logic [4:0]  rn, rt;
    longint      off;
    logic [32:0] exp;
    int          sent;
    longint      bnd[6] = '{255, -256, 256, -257, 0, -1};

    repeat (3) @(posedge clk);
    do_reset();
    run = 1;

    lat_req(STUR, 5'd2, 5'd1, -4, {1'b0, 32'hF81FC041});
    send(LDUR, 5'd0, 5'd0, 255, {1'b0, 32'hF84FF000}, 1'b1);
    send(LDUR, 5'd0, 5'd0, -256, {1'b0, 32'hF8500000}, 1'b1);
    drain();
`ifdef DADDR9_SAT_EN
    send(STUR, 5'd0, 5'd0, 256, {1'b1, 32'hF80FF000}, 1'b1);
`else
    send(STUR, 5'd0, 5'd0, 256, {1'b1, 32'hF8100000}, 1'b1);
`endif
    drain();
    check("err_after_256", {48'd0, err_count}, 64'd1);

    do_reset();
    for (int i = 0; i < 4; i++) begin
`ifdef DADDR9_SAT_EN
      send(STUR, 5'd0, 5'd0, 64'h8000_0000_0000_0000, {1'b1, 32'hF8100000}, 1'b1);
`else
      send(STUR, 5'd0, 5'd0, 64'h8000_0000_0000_0000, {1'b1, 32'hF8000000}, 1'b1);
`endif
      if (i == 2) begin
        drain();
        check("err_three", {48'd0, err_count}, 64'd3);
      end
    end
    drain();
    check("err_four", {48'd0, err_count}, 64'd4);
    check("err_w2_held", {62'd0, err2}, 64'd3);

    // Six back-to-back requests with a three-cycle output stall in the middle.
    saw_block = 0;
    sent = 0;
    opc = STUR; rn = 5'($urandom); rt = 5'($urandom);
    off = longint'($urandom_range(0, 511)) - 256;
    for (int c = 0; c < 40 && sent < 6; c++) begin
      cyc(1'b1, opc, rn, rt, off, ref_word(opc, rn, rt, off), !(c >= 2 && c < 5), acc);
      if (acc) begin
        sent++;
        rn = 5'($urandom); rt = 5'($urandom);
        off = longint'($urandom_range(0, 511)) - 256;
      end
    end
    check("stream_sent", 64'(sent), 64'd6);
    check("stream_blocked", {63'd0, saw_block}, 64'd1);
    drain();

    // Reset while both stages hold words.
    send(STUR, 5'd3, 5'd4, 8, ref_word(STUR, 5'd3, 5'd4, 8), 1'b0);
    send(LDUR, 5'd5, 5'd6, -8, ref_word(LDUR, 5'd5, 5'd6, -8), 1'b0);
    idle(1'b0);
    check("full_before_reset", {63'd0, out_valid}, 64'd1);
    do_reset();
    lat_req(LDUR, 5'd7, 5'd9, 100, ref_word(LDUR, 5'd7, 5'd9, 100));
    drain();

    // Randomized traffic with random backpressure.
    opc = STUR; rn = '0; rt = '0; off = 0;
    for (int c = 0; c < 400; c++) begin
      logic v;
      v = ($urandom_range(0, 3) != 0);
      cyc(v, opc, rn, rt, off, ref_word(opc, rn, rt, off), ($urandom_range(0, 3) != 0), acc);
      if (acc || !v) begin
        case ($urandom_range(0, 2))
          0: opc = STUR;
          1: opc = LDUR;
          default: opc = 11'($urandom);
        endcase
        rn = 5'($urandom); rt = 5'($urandom);
        case ($urandom_range(0, 3))
          0: off = longint'($urandom_range(0, 511)) - 256;
          1: off = bnd[$urandom_range(0, 5)];
          2: off = {$urandom, $urandom};
          default: off = longint'($urandom_range(0, 8191)) - 4096;
        endcase
      end
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
